// File: rtl/vedic_pkg.sv
// Shared types and constants for the iterative Vedic multiplier.
package vedic_pkg;

    localparam int WIDTH = 8;
    localparam int HALF  = WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble-pair selection per accumulation step.
    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_HL = 2'd1;
    localparam logic [1:0] STEP_LH = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

endpackage

// File: rtl/vedic_mul4.sv
// Combinational 4x4 Urdhva-Tiryagbhyam multiplier built from 2x2 Vedic
// cells and half-adder based ripple adders.

// Half adder: the basic cell everything else is built from.
module vedic_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// 2x2 Vedic cell: vertical and crosswise products folded with two half adders.
module vedic_mul2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic c1;

    assign p[0] = x[0] & y[0];
    vedic_ha u_ha_cross (.x(x[1] & y[0]), .y(x[0] & y[1]), .s(p[1]), .c(c1));
    vedic_ha u_ha_top   (.x(x[1] & y[1]), .y(c1),          .s(p[2]), .c(p[3]));
endmodule

// Ripple-carry adder; each bit is a full adder made of two half adders.
module vedic_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N:0]   sum
);
    logic [N:0]   carry;
    logic [N-1:0] s0;
    logic [N-1:0] c0;
    logic [N-1:0] c1;

    assign carry[0] = 1'b0;
    assign sum[N]   = carry[N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            vedic_ha u_ha0 (.x(x[gi]),  .y(y[gi]),     .s(s0[gi]),  .c(c0[gi]));
            vedic_ha u_ha1 (.x(s0[gi]), .y(carry[gi]), .s(sum[gi]), .c(c1[gi]));
            assign carry[gi+1] = c0[gi] | c1[gi];
        end
    endgenerate
endmodule

// 4x4 core: q0 + ((q1 + q2) << 2) + (q3 << 4), with the two low bits of q0
// passing straight through so the final adder is only 6 bits wide.
module vedic_mul4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] cross_sum;
    logic [6:0] upper_sum;
    logic       unused_upper_carry;

    vedic_mul2 u_ll (.x(x[1:0]), .y(y[1:0]), .p(q0));
    vedic_mul2 u_hl (.x(x[3:2]), .y(y[1:0]), .p(q1));
    vedic_mul2 u_lh (.x(x[1:0]), .y(y[3:2]), .p(q2));
    vedic_mul2 u_hh (.x(x[3:2]), .y(y[3:2]), .p(q3));

    vedic_rca #(.N(4)) u_cross (.x(q1), .y(q2), .sum(cross_sum));
    vedic_rca #(.N(6)) u_upper (
        .x   ({q3, q0[3:2]}),
        .y   ({1'b0, cross_sum}),
        .sum (upper_sum)
    );

    // 15*15 fits in 8 bits, so the adder's carry-out is always zero.
    assign unused_upper_carry = upper_sum[6];
    assign p = {upper_sum[5:0], q0[1:0]};
endmodule

// File: rtl/vedic_mul8_seq.sv
// Iterative 8x8 unsigned multiplier: one shared 4x4 Vedic core accumulates
// the four nibble partial products over four cycles.
module vedic_mul8_seq
    import vedic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*WIDTH-1:0] product
);
    state_t               state_reg, state_next;
    logic [1:0]           step_reg, step_next;
    logic [WIDTH-1:0]     op_a_reg, op_a_next;
    logic [WIDTH-1:0]     op_b_reg, op_b_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;

    logic [HALF-1:0]      core_x;
    logic [HALF-1:0]      core_y;
    logic [WIDTH-1:0]     pp;
    logic [2*WIDTH-1:0]   addend;

    vedic_mul4 u_core (.x(core_x), .y(core_y), .p(pp));

    // Select the nibble pair for this step and align its partial product.
    always_comb begin
        core_x = op_a_reg[HALF-1:0];
        core_y = op_b_reg[HALF-1:0];
        addend = {8'h00, pp};
        case (step_reg)
            STEP_HL: begin
                core_x = op_a_reg[WIDTH-1:HALF];
                core_y = op_b_reg[HALF-1:0];
                addend = {4'h0, pp, 4'h0};
            end
            STEP_LH: begin
                core_x = op_a_reg[HALF-1:0];
                core_y = op_b_reg[WIDTH-1:HALF];
                addend = {4'h0, pp, 4'h0};
            end
            STEP_HH: begin
                core_x = op_a_reg[WIDTH-1:HALF];
                core_y = op_b_reg[WIDTH-1:HALF];
                addend = {pp, 8'h00};
            end
            default: ;
        endcase
    end

    // Next-state and datapath update for accept, accumulate and hand-off.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        acc_next   = acc_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    op_a_next  = a;
                    op_b_next  = b;
                    acc_next   = '0;
                    step_next  = STEP_LL;
                    state_next = MUL;
                end
            end
            MUL: begin
                acc_next  = acc_reg + addend;
                step_next = step_reg + 2'd1;
                if (step_reg == STEP_HH) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            step_reg  <= STEP_LL;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            acc_reg   <= acc_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign product   = acc_reg;

endmodule

// File: doc/vedic_mul8_seq.md
# vedic_mul8_seq

Iterative 8x8 unsigned Vedic multiplier. It reuses one combinational 4x4 Vedic core, built from 2x2 Vedic cells and the team's half adder, over four clock cycles, and shift-accumulates the four nibble partial products into a 16-bit result. It sits directly downstream of the half-adder/2x2 cell layer and upstream of any consumer of products. Valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand width; fixed at 8 for this revision, must be even; HALF = WIDTH/2 = 4.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset; asynchronous assert, released synchronously by the system.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts product.
- product  output  16  a*b, registered.

## Operation
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a and b into op_a and op_b;
  - clear acc to 0 and step to 0;
  - go to MUL.
- MUL: one partial product per cycle. pp = vedic_mul4(x, y) is 8 bits. acc <= acc + (pp << shift). The step sequence is:
  - step 0: op_a[3:0]*op_b[3:0], shift 0
  - step 1: op_a[7:4]*op_b[3:0], shift 4
  - step 2: op_a[3:0]*op_b[7:4], shift 4
  - step 3: op_a[7:4]*op_b[7:4], shift 8
- After the step-3 update, go to DONE. Step is a 2-bit counter that is not reused outside MUL.
- DONE: out_valid=1. product = acc and is held stable. On out_valid&&out_ready, go to IDLE. product keeps its last value until the next accepted operation clears acc.
- Arithmetic: acc is 16 bits. The maximum sum is 0xFE01, so overflow cannot occur. Truncation to 16 bits is exact.
- in_valid while not in IDLE is ignored; the operands are not queued. a and b are sampled only at the accept edge, so later changes have no effect.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes. The new input is accepted no earlier than the following cycle, when the block is in IDLE.
- Reset mid-operation: state goes to IDLE; acc, op_a, op_b and step are cleared; out_valid=0. The partial result is discarded.
- Reset values: in_ready=1, out_valid=0, product=16'h0000.

## Timing
- Accept edge E0 → step updates on E1..E4 → out_valid high in the cycle after E4. Latency is 4 cycles from accept to out_valid.
- Throughput: at most one product every 6 cycles when out_ready is held high (accept, 4 steps, DONE→IDLE, then IDLE accept).
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- The vedic_mul4 path is the critical path: mux plus 4x4 core plus 16-bit add must fit in one cycle.

## Structure
- Package vedic_pkg holds:
  - the state enum (IDLE, MUL, DONE);
  - step constants STEP_LL=0, STEP_HL=1, STEP_LH=2, STEP_HH=3;
  - localparam HALF.
- Sub-module vedic_mul4: combinational 4x4 Urdhva multiplier built from four 2x2 cells plus adders using the half adder. It is instantiated once and its operands are muxed by step.
- A top-level FSM plus datapath in vedic_mul8_seq.

## Test plan
- Reset then idle: after rst_n release, in_ready=1, out_valid=0, product=0x0000.
- a=0x12, b=0x34, out_ready=1 → out_valid rises 4 cycles after accept with product=0x03A8; in_ready returns high the next cycle.
- Corner operands, in order: 0xFF*0xFF→0xFE01; 0x00*0xB7→0x0000; 0xA5*0x5A→0x3A02; 0x01*0xFF→0x00FF.
- Backpressure: out_ready held low for 3 cycles in DONE → product held at its value, out_valid=1, in_ready=0, and in_valid pulses are ignored. When out_ready rises, the handshake completes once.
- Reset mid-operation: rst_n pulsed low during step 2 of 0xFF*0xFF → immediately out_valid=0, in_ready=1. A following 0x03*0x05 produces 0x000F.
- Randomised back-to-back stream of 1000 operations with random in_valid/out_ready → each product equals a*b from a reference model. No product is lost or duplicated.
